// File: rtl/int_pkg.sv
// int_pkg: shared constants, FSM encoding and vector lookup for the interrupt controller
package int_pkg;
  localparam int NIRQ = 4;
  localparam logic [9:0] INT_VEC_0 = 10'h3FB;
  localparam logic [9:0] INT_VEC_1 = 10'h3FE;
  localparam logic [9:0] INT_VEC_2 = 10'h3FD;
  localparam logic [9:0] INT_VEC_3 = 10'h3FC;
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, SERVICE = 2'b10} state_t;
  function automatic logic [9:0] vec_of(input logic [1:0] idx);
    return idx == 2'd0 ? INT_VEC_0 : idx == 2'd1 ? INT_VEC_1 : idx == 2'd2 ? INT_VEC_2 : INT_VEC_3;
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: multi-flop synchroniser for one request line plus rising-edge pulse
module irq_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  assign rise = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: four-source fixed-priority interrupt controller with a single-level
// request/acknowledge/return handshake towards the CPU
module int_ctrl
  import int_pkg::*;
#(
  parameter int AW = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            ie_we,
  input  logic [NIRQ-1:0] ie_wd,
  input  logic            gie,
  input  logic            int_ack,
  input  logic            reti,
  output logic            int_req,
  output logic [AW-1:0]   vector,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] in_service,
  output logic [NIRQ-1:0] ie
);
  state_t state;
  logic [1:0] idx, win;
  logic [NIRQ-1:0] rise, eligible, clr;
  genvar i;
  for (i = 0; i < NIRQ; i++) begin : g_sync
    irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .din  (irq_in[i]),
      .rise (rise[i])
    );
  end
  always_comb begin
    eligible = gie ? pending & ie : '0;
    win = eligible[0] ? 2'd0 : eligible[1] ? 2'd1 : eligible[2] ? 2'd2 : 2'd3;
    clr = (state == REQ && int_ack) ? 4'b0001 << idx : '0;
  end
  // a fresh edge on the acknowledged line survives the clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      int_req    <= 1'b0;
      vector     <= '0;
      pending    <= '0;
      in_service <= '0;
      ie         <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (ie_we) ie <= ie_wd;
      case (state)
        IDLE:
          if (|eligible) begin
            idx     <= win;
            int_req <= 1'b1;
            vector  <= AW'(vec_of(win));
            state   <= REQ;
          end
        REQ:
          if (int_ack) begin
            in_service <= 4'b0001 << idx;
            int_req    <= 1'b0;
            state      <= SERVICE;
          end else if (!gie || !ie[idx]) begin
            int_req <= 1'b0;
            vector  <= '0;
            state   <= IDLE;
          end
        SERVICE:
          if (reti) begin
            in_service <= '0;
            vector     <= '0;
            state      <= IDLE;
          end
        default: begin
          int_req    <= 1'b0;
          vector     <= '0;
          in_service <= '0;
          state      <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: vector table, directed corner sequences and random traffic against a source-level model
module tb_int_ctrl;
  localparam int S = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] irq_in = '0, ie_wd = '0;
  logic ie_we = 1'b0, gie = 1'b0, int_ack = 1'b0, reti = 1'b0;
  logic int_req;
  logic [9:0] vector;
  logic [3:0] pending, in_service, ie;
  int n_cmp = 0, n_err = 0;
  logic [9:0] vt[4] = '{10'h3FB, 10'h3FE, 10'h3FD, 10'h3FC};
  logic [3:0] m_pend, m_ie;
  int m_req, m_svc;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  int_ctrl #(.AW(10), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .ie_we(ie_we), .ie_wd(ie_wd),
    .gie(gie), .int_ack(int_ack), .reti(reti), .int_req(int_req), .vector(vector),
    .pending(pending), .in_service(in_service), .ie(ie)
  );

  typedef struct {
    logic [3:0] irq; logic ie_we; logic [3:0] ie_wd; logic ack; logic reti;
    logic req; logic [9:0] vec; logic [3:0] pend; logic [3:0] svc; logic [3:0] ie;
  } row_t;
  row_t tbl[9];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an event is a 0->1 transition in the input samples taken S and S+1 edges ago
  task automatic m_reset();
    m_pend = '0; m_ie = '0; m_req = -1; m_svc = -1;
    q.delete();
    for (int k = 0; k <= S; k++) q.push_back(4'h0);
  endtask

  task automatic m_edge();
    logic [3:0] ev, clr;
    ev = q[S-1] & ~q[S];
    clr = '0;
    if (m_req >= 0) begin
      if (int_ack) begin m_svc = m_req; clr[m_req] = 1'b1; m_req = -1; end
      else if (!gie || !m_ie[m_req]) m_req = -1;
    end else if (m_svc >= 0) begin
      if (reti) m_svc = -1;
    end else if (gie) begin
      for (int k = 3; k >= 0; k--) if (m_pend[k] && m_ie[k]) m_req = k;
    end
    m_pend = (m_pend & ~clr) | ev;
    if (ie_we) m_ie = ie_wd;
    q.push_front(irq_in);
    void'(q.pop_back());
  endtask

  task automatic check_model();
    logic [9:0] ev;
    logic [3:0] es;
    ev = m_req >= 0 ? vt[m_req] : m_svc >= 0 ? vt[m_svc] : 10'h0;
    es = m_svc >= 0 ? 4'(1) << m_svc : 4'h0;
    chk("m_int_req", 16'(int_req), 16'(m_req >= 0));
    chk("m_vector", 16'(vector), 16'(ev));
    chk("m_pending", 16'(pending), 16'(m_pend));
    chk("m_in_service", 16'(in_service), 16'(es));
    chk("m_ie", 16'(ie), 16'(m_ie));
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    while (!int_req && n < max) begin step(); n++; end
    chk("wait_req", 16'(int_req), 16'd1);
  endtask

  task automatic ack_then_reti();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    reti = 1'b1; step(); reti = 1'b0;
  endtask

  initial begin
    int n, cnt;
    logic prev;
    tbl[0] = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF};
    tbl[1] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF};
    tbl[2] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF};
    tbl[3] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000, 4'h4, 4'h0, 4'hF};
    tbl[4] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'h3FD, 4'h4, 4'h0, 4'hF};
    tbl[5] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 10'h3FD, 4'h0, 4'h4, 4'hF};
    tbl[6] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h3FD, 4'h0, 4'h4, 4'hF};
    tbl[7] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF};
    tbl[8] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 4'h0, 4'hF};
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_int_req", 16'(int_req), 16'd0);
    chk("rst_vector", 16'(vector), 16'd0);
    chk("rst_pending", 16'(pending), 16'd0);
    chk("rst_ie", 16'(ie), 16'd0);
    @(negedge clk) reset = 1'b1;
    gie = 1'b1;
    // single source handshake, including ack/reti coincidence and out-of-state pulses
    for (int r = 0; r < 9; r++) begin
      irq_in = tbl[r].irq; ie_we = tbl[r].ie_we; ie_wd = tbl[r].ie_wd;
      int_ack = tbl[r].ack; reti = tbl[r].reti;
      step();
      chk($sformatf("t%0d_int_req", r), 16'(int_req), 16'(tbl[r].req));
      chk($sformatf("t%0d_vector", r), 16'(vector), 16'(tbl[r].vec));
      chk($sformatf("t%0d_pending", r), 16'(pending), 16'(tbl[r].pend));
      chk($sformatf("t%0d_in_service", r), 16'(in_service), 16'(tbl[r].svc));
      chk($sformatf("t%0d_ie", r), 16'(ie), 16'(tbl[r].ie));
    end
    ie_we = 1'b0; int_ack = 1'b0; reti = 1'b0;
    // simultaneous sources: priority then back-to-back service
    irq_in = 4'b1001;
    wait_req(6, n);
    chk("prio_vec0", 16'(vector), 16'h3FB);
    ack_then_reti();
    step();
    chk("prio_second_req", 16'(int_req), 16'd1);
    chk("prio_vec3", 16'(vector), 16'h3FC);
    ack_then_reti();
    irq_in = 4'h0;
    // disabled source stays pending; enabling it raises the request
    ie_we = 1'b1; ie_wd = 4'h0; step(); ie_we = 1'b0;
    irq_in = 4'b0010;
    repeat (4) step();
    chk("dis_pending", 16'(pending), 16'h2);
    chk("dis_int_req", 16'(int_req), 16'd0);
    ie_we = 1'b1; ie_wd = 4'b0010; step(); ie_we = 1'b0;
    wait_req(2, n);
    chk("en_vec1", 16'(vector), 16'h3FE);
    // re-trigger of the serviced source during SERVICE
    int_ack = 1'b1; step(); int_ack = 1'b0;
    irq_in = 4'h0; repeat (3) step();
    irq_in = 4'b0010; repeat (4) step();
    chk("svc_pending", 16'(pending), 16'h2);
    chk("svc_in_service", 16'(in_service), 16'h2);
    irq_in = 4'h0;
    reti = 1'b1; step(); reti = 1'b0;
    step();
    chk("svc_rereq", 16'(int_req), 16'd1);
    chk("svc_revec", 16'(vector), 16'h3FE);
    ack_then_reti();
    // held level yields exactly one request
    ie_we = 1'b1; ie_wd = 4'hF; step(); ie_we = 1'b0;
    irq_in = 4'b1000; cnt = 0; prev = int_req;
    for (int k = 0; k < 50; k++) begin
      int_ack = int_req; reti = |in_service;
      step();
      if (int_req && !prev) cnt++;
      prev = int_req;
    end
    int_ack = 1'b0; reti = 1'b0;
    chk("held_one_req", 16'(cnt), 16'd1);
    irq_in = 4'h0; repeat (3) step();
    irq_in = 4'b1000;
    wait_req(6, n);
    chk("held_second_vec", 16'(vector), 16'h3FC);
    // asynchronous reset mid-cycle while in REQ
    #3 reset = 1'b0;
    #1;
    chk("arst_int_req", 16'(int_req), 16'd0);
    chk("arst_vector", 16'(vector), 16'd0);
    chk("arst_pending", 16'(pending), 16'd0);
    chk("arst_in_service", 16'(in_service), 16'd0);
    chk("arst_ie", 16'(ie), 16'd0);
    m_reset();
    @(negedge clk) reset = 1'b1;
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("stray_ack", 16'(in_service), 16'd0);
    irq_in = 4'h0;
    // random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'($urandom);
      ie_we = $urandom_range(0, 7) == 0;
      ie_wd = 4'($urandom);
      gie = $urandom_range(0, 7) != 0;
      int_ack = $urandom_range(0, 2) == 0;
      reti = $urandom_range(0, 3) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
